xbar_cfg_loader: RTL

Loads crossbar select configuration from a valid/ready stream into a shadow register, validates the frame, then commits it atomically to the flat io_mux_configs bus that drives the tile crossbar. The crossbar never sees a partially written or illegal configuration. It sits between the tile config bus and the xbar, one instance per LUT tile.

---
 rtl/xbar_cfg_pkg.sv | 22 ++
 rtl/xbar_cfg_shadow.sv | 32 +++
 rtl/xbar_cfg_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/xbar_cfg_pkg.sv
// Shared types and constants for the crossbar configuration loader.
// Frame states, rejection codes and default geometry of one LUT tile crossbar.
package xbar_cfg_pkg;

   localparam int DEF_NUM_IN  = 18;
   localparam int DEF_NUM_OUT = 20;
   localparam int DEF_SEL_W   = 5;
   localparam int DEF_EPOCH_W = 8;
   localparam int CFG_W       = DEF_NUM_OUT * DEF_SEL_W;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SEL   = 2'd1;
   localparam logic [1:0] ERR_SHORT = 2'd2;
   localparam logic [1:0] ERR_LONG  = 2'd3;

endpackage

// File: rtl/xbar_cfg_shadow.sv
// Shadow select store written one output at a time, plus the active register
// that is only ever loaded from the shadow as a whole.
module xbar_cfg_shadow #(
   parameter int NUM_OUT = 20,
   parameter int SEL_W   = 5,
   parameter int IDX_W   = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [IDX_W-1:0]         idx,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     commit,
   output logic [NUM_OUT*SEL_W-1:0] active
);

   logic [NUM_OUT*SEL_W-1:0] shadow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow <= '0;
         active <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (we && idx == IDX_W'(k)) shadow[k*SEL_W +: SEL_W] <= sel;
         end
         // Writes and commits never coincide, so active always sees a complete frame.
         if (commit) active <= shadow;
      end
   end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Streams a crossbar select frame into a shadow store, validates length and
// select range, and commits it atomically to io_mux_configs.
module xbar_cfg_loader
   import xbar_cfg_pkg::*;
#(
   parameter int NUM_IN  = DEF_NUM_IN,
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int SEL_W   = DEF_SEL_W,
   parameter int EPOCH_W = DEF_EPOCH_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [SEL_W-1:0]         cfg_sel,
   input  logic                     cfg_last,
   input  logic                     cfg_abort,
   output logic [NUM_OUT*SEL_W-1:0] io_mux_configs,
   output logic                     cfg_done,
   output logic                     cfg_err,
   output logic [1:0]               cfg_err_code,
   output logic                     cfg_loaded,
   output logic [EPOCH_W-1:0]       cfg_epoch
);

   localparam int IDX_W = $clog2(NUM_OUT);

   // Handshake: a beat transfers on any edge where cfg_valid && cfg_ready;
   // cfg_ready depends only on state, never on cfg_valid.
   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic             bad, bad_n;
   logic             done_n, err_n, we, commit;
   logic [1:0]       code_n;
   logic             accept, sel_bad, at_end;

   assign cfg_ready = (state != COMMIT);
   assign accept    = cfg_valid && cfg_ready;
   assign sel_bad   = ({1'b0, cfg_sel} >= (SEL_W+1)'(NUM_IN));
   assign at_end    = (idx == IDX_W'(NUM_OUT-1));

   always_comb begin
      state_n = state;
      idx_n   = idx;
      bad_n   = bad;
      done_n  = 1'b0;
      err_n   = 1'b0;
      code_n  = ERR_NONE;
      we      = 1'b0;
      commit  = 1'b0;
      unique case (state)
         LOAD: begin
            if (cfg_abort) begin
               idx_n = '0;
               bad_n = 1'b0;
            end else if (accept) begin
               we    = 1'b1;
               bad_n = bad | sel_bad;
               if (cfg_last && at_end) begin
                  state_n = COMMIT;
               end else if (cfg_last) begin
                  // An illegal select outranks the length problem.
                  err_n  = 1'b1;
                  code_n = (bad | sel_bad) ? ERR_SEL : ERR_SHORT;
                  idx_n  = '0;
                  bad_n  = 1'b0;
               end else if (at_end) begin
                  state_n = DRAIN;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         DRAIN: begin
            if (cfg_abort) begin
               state_n = LOAD;
               idx_n   = '0;
               bad_n   = 1'b0;
            end else if (accept && cfg_last) begin
               err_n   = 1'b1;
               code_n  = bad ? ERR_SEL : ERR_LONG;
               state_n = LOAD;
               idx_n   = '0;
               bad_n   = 1'b0;
            end
         end
         COMMIT: begin
            if (bad) begin
               err_n  = 1'b1;
               code_n = ERR_SEL;
            end else begin
               commit = 1'b1;
               done_n = 1'b1;
            end
            state_n = LOAD;
            idx_n   = '0;
            bad_n   = 1'b0;
         end
         default: begin
            state_n = LOAD;
            idx_n   = '0;
            bad_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= LOAD;
         idx          <= '0;
         bad          <= 1'b0;
         cfg_done     <= 1'b0;
         cfg_err      <= 1'b0;
         cfg_err_code <= ERR_NONE;
         cfg_loaded   <= 1'b0;
         cfg_epoch    <= '0;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         bad          <= bad_n;
         cfg_done     <= done_n;
         cfg_err      <= err_n;
         cfg_err_code <= code_n;
         if (commit) begin
            cfg_loaded <= 1'b1;
            cfg_epoch  <= cfg_epoch + EPOCH_W'(1);
         end
      end
   end

   xbar_cfg_shadow #(
      .NUM_OUT (NUM_OUT),
      .SEL_W   (SEL_W),
      .IDX_W   (IDX_W)
   ) u_shadow (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .idx     (idx),
      .sel     (cfg_sel),
      .commit  (commit),
      .active  (io_mux_configs)
   );

endmodule
